inst_decode_queue: RTL and testbench

INST_DECODE_QUEUE -- requirements
Module: inst_decode_queue

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/inst_decode_comb.sv | 164 ++++++++++++++++
 rtl/inst_decode_queue.sv | 168 ++++++++++++++++
 tb/tb_inst_decode_queue.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: operation codes, format classes, RV32I major
// opcodes and the NULL register-index encoding (MSB of the index set).
package cpu_pkg;

  typedef enum logic [5:0] {
    OP_ILLEGAL = 6'd0,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND
  } op_e;

  typedef enum logic [2:0] {
    TYPE_R       = 3'd0,
    TYPE_I       = 3'd1,
    TYPE_ILOAD   = 3'd2,
    TYPE_S       = 3'd3,
    TYPE_B       = 3'd4,
    TYPE_U       = 3'd5,
    TYPE_J       = 3'd6,
    TYPE_ILLEGAL = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // NULL register index for a w-bit index field: only the MSB set.
  function automatic logic [15:0] reg_null(input int w);
    reg_null = 16'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/inst_decode_comb.sv
// Purely combinational RV32I decoder. Operand fields an instruction does
// not use come out as the NULL index; illegal encodings give type ILLEGAL,
// all indices NULL and a zero immediate.
module inst_decode_comb
  import cpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int REG_W = 6
) (
  input  logic [31:0]      inst_i,
  output logic [5:0]       op_o,
  output logic [2:0]       type_o,
  output logic [REG_W-1:0] rs1_o,
  output logic [REG_W-1:0] rs2_o,
  output logic [REG_W-1:0] rd_o,
  output logic [XLEN-1:0]  imm_o
);

  localparam logic [REG_W-1:0] REG_NULL = REG_W'(reg_null(REG_W));

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  op_e         op;
  fmt_e        fmt;
  logic        use_rs1, use_rs2, use_rd;

  assign opc   = inst_i[6:0];
  assign f3    = inst_i[14:12];
  assign f7    = inst_i[31:25];
  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'd0};
  assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  // Classify the opcode/funct fields and pick operands and immediate.
  always_comb begin
    op      = OP_ILLEGAL;
    fmt     = TYPE_ILLEGAL;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    imm32   = '0;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        op     = (opc == OPC_LUI) ? OP_LUI : OP_AUIPC;
        fmt    = TYPE_U;
        use_rd = 1'b1;
        imm32  = imm_u;
      end
      OPC_JAL: begin
        op     = OP_JAL;
        fmt    = TYPE_J;
        use_rd = 1'b1;
        imm32  = imm_j;
      end
      OPC_JALR: begin
        if (f3 == 3'b000) begin
          op      = OP_JALR;
          fmt     = TYPE_I;
          use_rd  = 1'b1;
          use_rs1 = 1'b1;
          imm32   = imm_i;
        end
      end
      OPC_BRANCH: begin
        case (f3)
          3'b000:  op = OP_BEQ;
          3'b001:  op = OP_BNE;
          3'b100:  op = OP_BLT;
          3'b101:  op = OP_BGE;
          3'b110:  op = OP_BLTU;
          3'b111:  op = OP_BGEU;
          default: op = OP_ILLEGAL;
        endcase
        if (op != OP_ILLEGAL) begin
          fmt     = TYPE_B;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          imm32   = imm_b;
        end
      end
      OPC_LOAD: begin
        case (f3)
          3'b000:  op = OP_LB;
          3'b001:  op = OP_LH;
          3'b010:  op = OP_LW;
          3'b100:  op = OP_LBU;
          3'b101:  op = OP_LHU;
          default: op = OP_ILLEGAL;
        endcase
        if (op != OP_ILLEGAL) begin
          fmt     = TYPE_ILOAD;
          use_rd  = 1'b1;
          use_rs1 = 1'b1;
          imm32   = imm_i;
        end
      end
      OPC_STORE: begin
        case (f3)
          3'b000:  op = OP_SB;
          3'b001:  op = OP_SH;
          3'b010:  op = OP_SW;
          default: op = OP_ILLEGAL;
        endcase
        if (op != OP_ILLEGAL) begin
          fmt     = TYPE_S;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
          imm32   = imm_s;
        end
      end
      OPC_OPIMM: begin
        case (f3)
          3'b000:  op = OP_ADDI;
          3'b010:  op = OP_SLTI;
          3'b011:  op = OP_SLTIU;
          3'b100:  op = OP_XORI;
          3'b110:  op = OP_ORI;
          3'b111:  op = OP_ANDI;
          3'b001:  op = (f7 == F7_BASE) ? OP_SLLI : OP_ILLEGAL;
          default: op = (f7 == F7_BASE) ? OP_SRLI : ((f7 == F7_ALT) ? OP_SRAI : OP_ILLEGAL);
        endcase
        if (op != OP_ILLEGAL) begin
          fmt     = TYPE_I;
          use_rd  = 1'b1;
          use_rs1 = 1'b1;
          imm32   = imm_i;
        end
      end
      OPC_OP: begin
        case ({f7, f3})
          {F7_BASE, 3'b000}: op = OP_ADD;
          {F7_ALT,  3'b000}: op = OP_SUB;
          {F7_BASE, 3'b001}: op = OP_SLL;
          {F7_BASE, 3'b010}: op = OP_SLT;
          {F7_BASE, 3'b011}: op = OP_SLTU;
          {F7_BASE, 3'b100}: op = OP_XOR;
          {F7_BASE, 3'b101}: op = OP_SRL;
          {F7_ALT,  3'b101}: op = OP_SRA;
          {F7_BASE, 3'b110}: op = OP_OR;
          {F7_BASE, 3'b111}: op = OP_AND;
          default:           op = OP_ILLEGAL;
        endcase
        if (op != OP_ILLEGAL) begin
          fmt     = TYPE_R;
          use_rd  = 1'b1;
          use_rs1 = 1'b1;
          use_rs2 = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign op_o   = op;
  assign type_o = fmt;
  assign rs1_o  = use_rs1 ? REG_W'(inst_i[19:15]) : REG_NULL;
  assign rs2_o  = use_rs2 ? REG_W'(inst_i[24:20]) : REG_NULL;
  assign rd_o   = use_rd  ? REG_W'(inst_i[11:7])  : REG_NULL;
  assign imm_o  = XLEN'($signed(imm32));

endmodule

// File: rtl/inst_decode_queue.sv
// Instruction queue: DEPTH-entry FIFO followed by one decode/output
// register. Optional build macro DECQ_BYPASS_EN lets a push into an empty
// queue with a free output stage load the output register directly.
module inst_decode_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int REG_W = 6
) (
  input  logic                     clk_in,
  input  logic                     rstn_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_inst,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5:0]               out_op,
  output logic [2:0]               out_type,
  output logic [REG_W-1:0]         out_rs1,
  output logic [REG_W-1:0]         out_rs2,
  output logic [REG_W-1:0]         out_rd,
  output logic [XLEN-1:0]          out_imm,
  output logic [XLEN-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [REG_W-1:0] REG_NULL = REG_W'(reg_null(REG_W));

  logic [XLEN-1:0]  mem_inst_q [DEPTH];
  logic [XLEN-1:0]  mem_pc_q   [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty, out_free, push, pop, bypass, load_out;
  logic [XLEN-1:0]  dec_inst, dec_pc, dec_imm;
  logic [5:0]       dec_op;
  logic [2:0]       dec_type;
  logic [REG_W-1:0] dec_rs1, dec_rs2, dec_rd;

  logic             out_valid_q, out_valid_d;
  logic [5:0]       out_op_q, out_op_d;
  logic [2:0]       out_type_q, out_type_d;
  logic [REG_W-1:0] out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d, out_rd_q, out_rd_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d, out_pc_q, out_pc_d;

  // Handshake qualification; flush and a low rdy_in block every transfer.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    out_free = !out_valid_q || out_ready;
`ifdef DECQ_BYPASS_EN
    bypass   = in_valid && rdy_in && !flush_in && empty && out_free;
`else
    bypass   = 1'b0;
`endif
    push     = in_valid && !full && rdy_in && !flush_in && !bypass;
    pop      = !empty && out_free && rdy_in && !flush_in;
    load_out = pop || bypass;
    dec_inst = bypass ? in_inst : mem_inst_q[rd_ptr_q];
    dec_pc   = bypass ? in_pc   : mem_pc_q[rd_ptr_q];
  end

  inst_decode_comb #(
    .XLEN  (XLEN),
    .REG_W (REG_W)
  ) u_decode (
    .inst_i (dec_inst[31:0]),
    .op_o   (dec_op),
    .type_o (dec_type),
    .rs1_o  (dec_rs1),
    .rs2_o  (dec_rs2),
    .rd_o   (dec_rd),
    .imm_o  (dec_imm)
  );

  // Next state of pointers, occupancy and the output register.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_type_d  = out_type_q;
    out_rs1_d   = out_rs1_q;
    out_rs2_d   = out_rs2_q;
    out_rd_d    = out_rd_q;
    out_imm_d   = out_imm_q;
    out_pc_d    = out_pc_q;
    if (rdy_in) begin
      if (flush_in) begin
        wr_ptr_d    = '0;
        rd_ptr_d    = '0;
        count_d     = '0;
        out_valid_d = 1'b0;
      end else begin
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(push) - CW'(pop);
        if (load_out) begin
          out_valid_d = 1'b1;
          out_op_d    = dec_op;
          out_type_d  = dec_type;
          out_rs1_d   = dec_rs1;
          out_rs2_d   = dec_rs2;
          out_rd_d    = dec_rd;
          out_imm_d   = dec_imm;
          out_pc_d    = dec_pc;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
    end
  end

  // Control and output-stage registers, cleared asynchronously by reset.
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_type_q  <= '0;
      out_rs1_q   <= REG_NULL;
      out_rs2_q   <= REG_NULL;
      out_rd_q    <= REG_NULL;
      out_imm_q   <= '0;
      out_pc_q    <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_type_q  <= out_type_d;
      out_rs1_q   <= out_rs1_d;
      out_rs2_q   <= out_rs2_d;
      out_rd_q    <= out_rd_d;
      out_imm_q   <= out_imm_d;
      out_pc_q    <= out_pc_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_inst_q[wr_ptr_q] <= in_inst;
      mem_pc_q[wr_ptr_q]   <= in_pc;
    end
  end

  assign in_ready  = !full;
  assign out_valid = out_valid_q;
  assign out_op    = out_op_q;
  assign out_type  = out_type_q;
  assign out_rs1   = out_rs1_q;
  assign out_rs2   = out_rs2_q;
  assign out_rd    = out_rd_q;
  assign out_imm   = out_imm_q;
  assign out_pc    = out_pc_q;
  assign count_out = count_q;

endmodule

// File: tb/tb_inst_decode_queue.sv
// Directed bench for inst_decode_queue (DEPTH=4, XLEN=32, REG_W=6).
module tb_inst_decode_queue;
  import cpu_pkg::*;

  logic        clk, rstn, rdy, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_imm, out_pc;
  logic [5:0]  out_op, out_rs1, out_rs2, out_rd;
  logic [2:0]  out_type, count_out;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [5:0] NUL = 6'h20;

  logic [31:0] insts [6];

  inst_decode_queue #(.DEPTH(4), .XLEN(32), .REG_W(6)) dut (
    .clk_in    (clk),
    .rstn_in   (rstn),
    .rdy_in    (rdy),
    .flush_in  (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_type  (out_type),
    .out_rs1   (out_rs1),
    .out_rs2   (out_rs2),
    .out_rd    (out_rd),
    .out_imm   (out_imm),
    .out_pc    (out_pc),
    .count_out (count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [5:0] op, input logic [2:0] ty,
                         input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rd,
                         input logic [31:0] imm, input logic [31:0] pc);
    $display("out %s: valid=%0b op=%0d type=%0d rs1=%0h rs2=%0h rd=%0h imm=%0h pc=%0h",
             tag, out_valid, out_op, out_type, out_rs1, out_rs2, out_rd, out_imm, out_pc);
    check({tag, ".valid"}, 64'(out_valid), 64'(1));
    check({tag, ".op"},    64'(out_op),    64'(op));
    check({tag, ".type"},  64'(out_type),  64'(ty));
    check({tag, ".rs1"},   64'(out_rs1),   64'(rs1));
    check({tag, ".rs2"},   64'(out_rs2),   64'(rs2));
    check({tag, ".rd"},    64'(out_rd),    64'(rd));
    check({tag, ".imm"},   64'(out_imm),   64'(imm));
    check({tag, ".pc"},    64'(out_pc),    64'(pc));
  endtask

  // Push insts[0..4] back to back with out_ready low: one lands in the
  // output stage, four fill the FIFO.
  task automatic fill5();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_inst  = insts[k];
      in_pc    = 32'(k * 4);
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    insts[0] = 32'h00500093;  // addi x1,x0,5
    insts[1] = 32'hFFFFFFFF;  // illegal
    insts[2] = 32'h002081B3;  // add  x3,x1,x2
    insts[3] = 32'h000000B7;  // lui  x1,0
    insts[4] = 32'h00812023;  // sw   x8,0(x2)
    insts[5] = 32'h00000013;  // addi x0,x0,0

    rstn = 1'b1; rdy = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    #1 rstn = 1'b0;
    #2;
    check("rst.valid", 64'(out_valid), 64'(0));
    check("rst.count", 64'(count_out), 64'(0));
    check("rst.op",    64'(out_op),    64'(0));
    check("rst.type",  64'(out_type),  64'(0));
    check("rst.rs1",   64'(out_rs1),   64'(NUL));
    check("rst.rs2",   64'(out_rs2),   64'(NUL));
    check("rst.rd",    64'(out_rd),    64'(NUL));
    check("rst.imm",   64'(out_imm),   64'(0));
    check("rst.pc",    64'(out_pc),    64'(0));
    check("rst.in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rstn = 1'b1;
    rdy  = 1'b1;
    step();

    // ADDI through the queue
    in_valid = 1'b1; in_inst = insts[0]; in_pc = 32'h0;
    step();
    in_valid = 1'b0;
`ifndef DECQ_BYPASS_EN
    check("addi.edge1.valid", 64'(out_valid), 64'(0));
    check("addi.edge1.count", 64'(count_out), 64'(1));
`endif
    step();
    chk_out("addi", OP_ADDI, TYPE_I, 6'd0, NUL, 6'd1, 32'd5, 32'h0);
    check("addi.count", 64'(count_out), 64'(0));
    step();
    check("addi.hold.valid", 64'(out_valid), 64'(1));
    check("addi.hold.imm",   64'(out_imm),   64'(5));
    out_ready = 1'b1;
    step();
    check("addi.consumed.valid", 64'(out_valid), 64'(0));
    out_ready = 1'b0;

    // BEQ x1,x2,-4
    in_valid = 1'b1; in_inst = 32'hFE208EE3; in_pc = 32'h100;
    step();
    in_valid = 1'b0;
    step();
    chk_out("beq", OP_BEQ, TYPE_B, 6'd1, 6'd2, NUL, 32'hFFFFFFFC, 32'h100);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Overfill: 5 accepted, 6th held off, then drain in order
    fill5();
    check("full.count",    64'(count_out), 64'(4));
    check("full.in_ready", 64'(in_ready),  64'(0));
    chk_out("full.head", OP_ADDI, TYPE_I, 6'd0, NUL, 6'd1, 32'd5, 32'h0);
    in_valid = 1'b1; in_inst = insts[5]; in_pc = 32'h14;
    step();
    check("sixth.count",    64'(count_out), 64'(4));
    check("sixth.in_ready", 64'(in_ready),  64'(0));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk_out("drain1", OP_ILLEGAL, TYPE_ILLEGAL, NUL, NUL, NUL, 32'd0, 32'h4);
    check("drain1.count", 64'(count_out), 64'(3));
    step();
    chk_out("drain2", OP_ADD, TYPE_R, 6'd1, 6'd2, 6'd3, 32'd0, 32'h8);
    step();
    chk_out("drain3", OP_LUI, TYPE_U, NUL, NUL, 6'd1, 32'd0, 32'hC);
    step();
    chk_out("drain4", OP_SW, TYPE_S, 6'd2, 6'd8, NUL, 32'd0, 32'h10);
    check("drain4.count", 64'(count_out), 64'(0));
    step();
    check("drain.empty.valid", 64'(out_valid), 64'(0));
    out_ready = 1'b0;

    // Flush a full queue while fetch is still pushing
    fill5();
    in_valid = 1'b1; in_inst = insts[5]; in_pc = 32'h20;
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush.count",    64'(count_out), 64'(0));
    check("flush.valid",    64'(out_valid), 64'(0));
    check("flush.in_ready", 64'(in_ready),  64'(1));
    step();
    step();
    check("flush.nopush.count", 64'(count_out), 64'(0));
    check("flush.nopush.valid", 64'(out_valid), 64'(0));

    // rdy_in low freezes everything
    rdy = 1'b0; in_valid = 1'b1; in_inst = insts[0]; in_pc = 32'h30;
    step();
    step();
    check("frozen.count", 64'(count_out), 64'(0));
    check("frozen.valid", 64'(out_valid), 64'(0));
    in_valid = 1'b0; rdy = 1'b1;

    // Full: pop only; then simultaneous push and pop keeps the count
    fill5();
    in_valid = 1'b1; in_inst = insts[5]; in_pc = 32'h14;
    out_ready = 1'b1;
    step();
    check("fullpop.count",    64'(count_out), 64'(3));
    check("fullpop.in_ready", 64'(in_ready),  64'(1));
    step();
    check("pushpop.count", 64'(count_out), 64'(3));
    chk_out("pushpop.out", OP_ADD, TYPE_R, 6'd1, 6'd2, 6'd3, 32'd0, 32'h8);
    in_valid = 1'b0; out_ready = 1'b0;

    // Asynchronous reset mid-operation, between clock edges
    #2 rstn = 1'b0;
    #1;
    check("arst.count", 64'(count_out), 64'(0));
    check("arst.valid", 64'(out_valid), 64'(0));
    check("arst.rs1",   64'(out_rs1),   64'(NUL));
    check("arst.pc",    64'(out_pc),    64'(0));
    @(negedge clk);
    rstn = 1'b1;
    step();

    // LUI into an empty queue
    in_valid = 1'b1; in_inst = 32'h000000B7; in_pc = 32'h40;
    step();
    in_valid = 1'b0;
`ifdef DECQ_BYPASS_EN
    check("lui.byp.count", 64'(count_out), 64'(0));
    chk_out("lui.byp", OP_LUI, TYPE_U, NUL, NUL, 6'd1, 32'd0, 32'h40);
`else
    check("lui.edge1.count", 64'(count_out), 64'(1));
    check("lui.edge1.valid", 64'(out_valid), 64'(0));
    step();
    check("lui.count", 64'(count_out), 64'(0));
    chk_out("lui", OP_LUI, TYPE_U, NUL, NUL, 6'd1, 32'd0, 32'h40);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
